clk_gate_ctrl: RTL

CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

---
 rtl/clk_gate_pkg.sv | 15 +
 rtl/clk_gate_ctrl_if.sv | 23 ++
 rtl/clk_gate_cell.sv | 18 +
 rtl/clk_gate_ctrl.sv | 111 +++++++++++
 4 files changed

// File: rtl/clk_gate_pkg.sv
// Shared types and limits for the per-channel clock-gating controller.
package clk_gate_pkg;
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_COUNT = 2'd1,
    ST_GATED = 2'd2,
    ST_WAKE  = 2'd3
  } cg_state_e;

  localparam int NCH_MIN      = 1;
  localparam int NCH_MAX      = 16;
  localparam int WAKE_CYC_MIN = 1;
  localparam int WAKE_CYC_MAX = 15;
  localparam int WAKE_W       = 4;
endpackage

// File: rtl/clk_gate_ctrl_if.sv
// Control/status bundle between the integrating logic and clk_gate_ctrl.
interface clk_gate_ctrl_if #(
  parameter int NCH    = 4,
  parameter int IDLE_W = 4
);
  logic [NCH-1:0]    auto_en;
  logic [NCH-1:0]    busy;
  logic [IDLE_W-1:0] idle_thresh;
  logic [NCH-1:0]    wake_req;
  logic [NCH-1:0]    wake_ack;
  logic [NCH-1:0]    GCK;
  logic [NCH-1:0]    gated;

  modport master (
    output auto_en, busy, idle_thresh, wake_req,
    input  wake_ack, GCK, gated
  );

  modport slave (
    input  auto_en, busy, idle_thresh, wake_req,
    output wake_ack, GCK, gated
  );
endinterface

// File: rtl/clk_gate_cell.sv
// Latch-based glitch-free clock gate: enable captured while clock is low,
// forced open during reset so downstream logic sees a running clock.
module clk_gate_cell (
  input  logic clk_i,
  input  logic rst_i,
  input  logic se_i,
  input  logic en_i,
  output logic gck_o
);
  logic en_l;

  always_latch begin
    if (rst_i)       en_l <= 1'b1;
    else if (!clk_i) en_l <= en_i | se_i;
  end

  assign gck_o = clk_i & en_l;
endmodule

// File: rtl/clk_gate_ctrl.sv
// Per-channel idle auto-gating controller with wake handshake; each channel
// owns an independent RUN/COUNT/GATED/WAKE FSM and a clk_gate_cell.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int IDLE_W   = 4,
  parameter int WAKE_CYC = 2
) (
  input  logic            CK,
  input  logic            RST,
  input  logic            SE,
  clk_gate_ctrl_if.slave  bus
);
  if (NCH < NCH_MIN || NCH > NCH_MAX) begin : g_bad_nch
    $error("clk_gate_ctrl: NCH out of range");
  end
  if (WAKE_CYC < WAKE_CYC_MIN || WAKE_CYC > WAKE_CYC_MAX) begin : g_bad_wake
    $error("clk_gate_ctrl: WAKE_CYC out of range");
  end

  localparam logic [WAKE_W-1:0] WAKE_END = WAKE_W'(WAKE_CYC);

  logic [NCH-1:0] gck, ack, gtd;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    cg_state_e         st_q, st_d;
    logic [IDLE_W-1:0] cnt_q, cnt_d, cnt_nxt;
    logic [WAKE_W-1:0] wcnt_q, wcnt_d;
    logic              ack_q, ack_d, srv_q, srv_d, gated_q, idle, en;

    // cnt_q is 0 in RUN, so the same increment yields the first idle count
    assign cnt_nxt = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign idle    = !bus.wake_req[c] && !bus.busy[c] && bus.auto_en[c];
    assign en      = (st_q != ST_GATED);

    always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
        st_q    <= ST_RUN;
        cnt_q   <= '0;
        wcnt_q  <= '0;
        ack_q   <= 1'b0;
        srv_q   <= 1'b0;
        gated_q <= 1'b0;
      end else begin
        st_q    <= st_d;
        cnt_q   <= cnt_d;
        wcnt_q  <= wcnt_d;
        ack_q   <= ack_d;
        srv_q   <= srv_d;
        gated_q <= (st_d == ST_GATED);
      end
    end

    always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      wcnt_d = wcnt_q;
      ack_d  = 1'b0;
      unique case (st_q)
        ST_RUN, ST_COUNT: begin
          st_d  = ST_RUN;
          cnt_d = '0;
          if (bus.wake_req[c]) begin
            ack_d = !srv_q;
          end else if (idle && (st_q == ST_COUNT || bus.idle_thresh != '0)) begin
            // gate on the edge that samples the idle_thresh-th idle cycle
            if (cnt_nxt == bus.idle_thresh) begin
              st_d = ST_GATED;
            end else begin
              st_d  = ST_COUNT;
              cnt_d = cnt_nxt;
            end
          end
        end
        ST_GATED: begin
          if (bus.wake_req[c] || bus.busy[c]) begin
            st_d   = ST_WAKE;
            wcnt_d = WAKE_W'(1);
          end
        end
        ST_WAKE: begin
          if (wcnt_q == WAKE_END) begin
            st_d  = ST_RUN;
            ack_d = 1'b1;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
        default: st_d = ST_RUN;
      endcase
      // one ack per request episode: re-armed only once wake_req drops
      srv_d = bus.wake_req[c] ? (srv_q | ack_d) : 1'b0;
    end

    clk_gate_cell u_cell (
      .clk_i (CK),
      .rst_i (RST),
      .se_i  (SE),
      .en_i  (en),
      .gck_o (gck[c])
    );

    assign ack[c] = ack_q;
    assign gtd[c] = gated_q;
  end

  assign bus.GCK      = gck;
  assign bus.wake_ack = ack;
  assign bus.gated    = gtd;
endmodule
